// File: rtl/width_conv_pkg.sv
// Shared definitions for the clka->clkb serial width-conversion path.
// The serializer, the downstream converter and their benches all import this package.
package width_conv_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StGap   = 2'd2
  } state_e;

  localparam int unsigned DefaultGapCycles = 4;

endpackage

// File: rtl/bit_serializer_if.sv
// Word handshake plus serial strobe/data bundle of the bit serializer.
// The master modport is the upstream word source; the slave modport is the serializer.
interface bit_serializer_if #(
  parameter int unsigned DATA_W = 8
);

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic              wra_n;
  logic              da;
  logic              busy;
  logic              frame_done;

  modport master (
    output s_data, s_valid,
    input  s_ready, wra_n, da, busy, frame_done
  );

  modport slave (
    input  s_data, s_valid,
    output s_ready, wra_n, da, busy, frame_done
  );

endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage: one-word hold buffer feeding an MSB-first shifter that drives
// an active-low strobe per word, followed by a fixed high gap for the downstream clkb sync.
module bit_serializer
  import width_conv_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned GAP_CYCLES = DefaultGapCycles
) (
  input  logic             clka,
  input  logic             rst,
  bit_serializer_if.slave  bus
);

  localparam int unsigned BitW = $clog2(DATA_W + 1);
  localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_W - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

  logic [DATA_W-1:0] r_hold;
  logic              r_hold_vld;
  logic [DATA_W-1:0] r_shift;
  logic [BitW-1:0]   r_bit_cnt;
  logic [GapW-1:0]   r_gap_cnt;
  state_e            r_state;
  logic              r_wra_n;
  logic              r_da;
  logic              r_frame_done;

  logic w_accept;
  logic w_load;

  assign w_accept = bus.s_valid & ~r_hold_vld;
  // The shifter takes the held word from IDLE, or straight from the last gap cycle.
  assign w_load   = r_hold_vld &
                    ((r_state == StIdle) || ((r_state == StGap) && (r_gap_cnt == GapLast)));

  always_ff @(posedge clka) begin
    if (rst) begin
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
    end else if (w_accept) begin
      r_hold     <= bus.s_data;
      r_hold_vld <= 1'b1;
    end else if (w_load) begin
      r_hold_vld <= 1'b0;
    end
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      r_state      <= StIdle;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_wra_n      <= 1'b1;
      r_da         <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_wra_n <= 1'b1;
          r_da    <= 1'b0;
          if (w_load) begin
            r_shift   <= r_hold;
            r_bit_cnt <= '0;
            r_state   <= StShift;
          end
        end
        StShift: begin
          r_wra_n <= 1'b0;
          r_da    <= r_shift[DATA_W-1];
          r_shift <= {r_shift[DATA_W-2:0], 1'b0};
          if (r_bit_cnt == BitLast) begin
            r_gap_cnt <= '0;
            r_state   <= StGap;
          end else begin
            r_bit_cnt <= r_bit_cnt + BitW'(1);
          end
        end
        StGap: begin
          r_wra_n      <= 1'b1;
          r_da         <= 1'b0;
          r_frame_done <= (r_gap_cnt == '0);
          if (r_gap_cnt == GapLast) begin
            if (w_load) begin
              r_shift   <= r_hold;
              r_bit_cnt <= '0;
              r_state   <= StShift;
            end else begin
              r_state <= StIdle;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + GapW'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.s_ready    = ~r_hold_vld;
  assign bus.wra_n      = r_wra_n;
  assign bus.da         = r_da;
  assign bus.frame_done = r_frame_done;
  assign bus.busy       = (r_state != StIdle) | r_hold_vld;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed and randomized checks of bit_serializer in three configurations (8/4, 8/10, 4/1),
// the 8/10 one feeding a behavioural clkb-side serial-to-parallel converter.
module tb_bit_serializer;

  logic clka;
  logic clkb;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;

  bit_serializer_if #(.DATA_W(8)) if8 ();
  bit_serializer_if #(.DATA_W(8)) ife ();
  bit_serializer_if #(.DATA_W(4)) if4 ();

  bit_serializer #(.DATA_W(8), .GAP_CYCLES(4))  u_dut8 (.clka(clka), .rst(rst), .bus(if8));
  bit_serializer #(.DATA_W(8), .GAP_CYCLES(10)) u_dute (.clka(clka), .rst(rst), .bus(ife));
  bit_serializer #(.DATA_W(4), .GAP_CYCLES(1))  u_dut4 (.clka(clka), .rst(rst), .bus(if4));

  initial begin
    clka = 1'b0;
    forever #5 clka = ~clka;
  end

  // clkb = clka/3, phase-offset so its edges never coincide with clka edges
  initial begin
    clkb = 1'b0;
    #2;
    forever #15 clkb = ~clkb;
  end

  // Downstream converter: shift in clka while strobe low, capture in clkb on synced rise
  logic [7:0] ds_sreg = 8'h00;
  logic       ds_s1 = 1'b1, ds_s2 = 1'b1, ds_s3 = 1'b1;
  logic [7:0] db_q[$];

  always @(posedge clka) if (ife.wra_n === 1'b0) ds_sreg <= {ds_sreg[6:0], ife.da};

  always @(posedge clkb) begin
    ds_s1 <= ife.wra_n;
    ds_s2 <= ds_s1;
    ds_s3 <= ds_s2;
    if (ds_s2 && !ds_s3) db_q.push_back(ds_sreg);
  end

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected 8/4 frame: DATA_W low cycles carrying MSB-first bits, then GAP high cycles
  task automatic run_frame8(input logic [7:0] w, input int first_bit, input logic exp_ready);
    for (int i = first_bit; i < 8; i++) begin
      tick();
      chk("bit_wra_n", {31'd0, if8.wra_n}, 32'd0);
      chk("bit_da", {31'd0, if8.da}, (32'(w) >> (7 - i)) & 32'd1);
      chk("bit_frame_done", {31'd0, if8.frame_done}, 32'd0);
      chk("bit_s_ready", {31'd0, if8.s_ready}, {31'd0, exp_ready});
    end
    for (int g = 0; g < 4; g++) begin
      tick();
      chk("gap_wra_n", {31'd0, if8.wra_n}, 32'd1);
      chk("gap_da", {31'd0, if8.da}, 32'd0);
      chk("gap_frame_done", {31'd0, if8.frame_done}, (g == 0) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic send_word8(input logic [7:0] w);
    if8.s_valid = 1'b1;
    if8.s_data  = w;
    tick();
    chk("acc_s_ready", {31'd0, if8.s_ready}, 32'd0);
    chk("acc_busy", {31'd0, if8.busy}, 32'd1);
    if8.s_valid = 1'b0;
    if8.s_data  = 8'($urandom);
    tick();
    chk("lat_wra_n", {31'd0, if8.wra_n}, 32'd1);
    run_frame8(w, 0, 1'b1);
    tick();
    chk("post_busy", {31'd0, if8.busy}, 32'd0);
    chk("post_wra_n", {31'd0, if8.wra_n}, 32'd1);
    chk("post_frame_done", {31'd0, if8.frame_done}, 32'd0);
  endtask

  logic [7:0] sent_q[$];
  logic [7:0] w8;
  logic [3:0] w4;
  logic       acc;

  initial begin
    rst = 1'b0;
    if8.s_valid = 1'b0; if8.s_data = '0;
    ife.s_valid = 1'b0; ife.s_data = '0;
    if4.s_valid = 1'b0; if4.s_data = '0;
    #1;

    // 1: reset with s_valid asserted
    rst = 1'b1;
    if8.s_valid = 1'b1;
    if8.s_data  = 8'($urandom);
    tick();
    tick();
    chk("rst_wra_n", {31'd0, if8.wra_n}, 32'd1);
    chk("rst_da", {31'd0, if8.da}, 32'd0);
    chk("rst_s_ready", {31'd0, if8.s_ready}, 32'd1);
    chk("rst_busy", {31'd0, if8.busy}, 32'd0);
    chk("rst_frame_done", {31'd0, if8.frame_done}, 32'd0);
    rst = 1'b0;
    if8.s_valid = 1'b0;
    tick();
    chk("rst_no_accept", {31'd0, if8.busy}, 32'd0);

    // 2: single word
    send_word8(8'hA5);

    // 3: s_valid held across two words, second accepted during the first SHIFT
    if8.s_valid = 1'b1;
    if8.s_data  = 8'h01;
    tick();
    chk("b2b_ready_e0", {31'd0, if8.s_ready}, 32'd0);
    if8.s_data = 8'h80;
    tick();
    chk("b2b_ready_e1", {31'd0, if8.s_ready}, 32'd1);
    chk("b2b_wra_n_e1", {31'd0, if8.wra_n}, 32'd1);
    tick();
    chk("b2b_wra_n_e2", {31'd0, if8.wra_n}, 32'd0);
    chk("b2b_da_e2", {31'd0, if8.da}, 32'd0);
    chk("b2b_ready_e2", {31'd0, if8.s_ready}, 32'd0);
    if8.s_valid = 1'b0;
    run_frame8(8'h01, 1, 1'b0);
    run_frame8(8'h80, 0, 1'b1);
    tick();
    chk("b2b_idle_busy", {31'd0, if8.busy}, 32'd0);

    // 4: reset after three bits of 8'hFF
    if8.s_valid = 1'b1;
    if8.s_data  = 8'hFF;
    tick();
    if8.s_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstmid_wra_n", {31'd0, if8.wra_n}, 32'd0);
      chk("rstmid_da", {31'd0, if8.da}, 32'd1);
    end
    rst = 1'b1;
    tick();
    chk("rstmid_after_wra_n", {31'd0, if8.wra_n}, 32'd1);
    chk("rstmid_after_fd", {31'd0, if8.frame_done}, 32'd0);
    chk("rstmid_after_busy", {31'd0, if8.busy}, 32'd0);
    chk("rstmid_after_ready", {31'd0, if8.s_ready}, 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("rstmid_quiet_wra_n", {31'd0, if8.wra_n}, 32'd1);
      chk("rstmid_quiet_fd", {31'd0, if8.frame_done}, 32'd0);
    end
    send_word8(8'h3C);

    // Random words with random idle spacing
    for (int k = 0; k < 6; k++) begin
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
        tick();
        chk("rand_idle_wra_n", {31'd0, if8.wra_n}, 32'd1);
      end
      send_word8(8'($urandom));
    end

    // 6: DATA_W=4, GAP_CYCLES=1
    for (int k = 0; k < 3; k++) begin
      w4 = (k == 0) ? 4'h9 : 4'($urandom);
      if4.s_valid = 1'b1;
      if4.s_data  = w4;
      tick();
      if4.s_valid = 1'b0;
      if4.s_data  = 4'($urandom);
      tick();
      chk("w4_lat_wra_n", {31'd0, if4.wra_n}, 32'd1);
      for (int i = 0; i < 4; i++) begin
        tick();
        chk("w4_wra_n", {31'd0, if4.wra_n}, 32'd0);
        chk("w4_da", {31'd0, if4.da}, (32'(w4) >> (3 - i)) & 32'd1);
      end
      tick();
      chk("w4_gap_wra_n", {31'd0, if4.wra_n}, 32'd1);
      chk("w4_gap_fd", {31'd0, if4.frame_done}, 32'd1);
      tick();
      chk("w4_idle_fd", {31'd0, if4.frame_done}, 32'd0);
      chk("w4_idle_busy", {31'd0, if4.busy}, 32'd0);
    end

    // 5: end-to-end through the clkb converter model, 256 random words
    db_q.delete();
    for (int k = 0; k < 256; k++) begin
      w8 = 8'($urandom);
      ife.s_valid = 1'b1;
      ife.s_data  = w8;
      acc = 1'b0;
      for (int t = 0; t < 100 && !acc; t++) begin
        acc = ife.s_ready;
        tick();
      end
      chk("e2e_accept", {31'd0, acc}, 32'd1);
      sent_q.push_back(w8);
      ife.s_valid = 1'b0;
      ife.s_data  = 8'($urandom);
      if ($urandom_range(0, 3) == 0) tick();
    end
    for (int t = 0; t < 400 && db_q.size() < 256; t++) tick();
    for (int t = 0; t < 60; t++) tick();
    chk("e2e_count", 32'(db_q.size()), 32'd256);
    for (int k = 0; k < 256 && k < db_q.size(); k++) begin
      chk("e2e_word", {24'd0, db_q[k]}, {24'd0, sent_q[k]});
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
